// File: rtl/matcher_pkg.sv
// Shared types and constants for the vocabulary word matcher.
package matcher_pkg;

  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned NUL_CHAR   = 0;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_REQ      = 3'd1,
    S_CMP      = 3'd2,
    S_SKIP_REQ = 3'd3,
    S_SKIP_CMP = 3'd4,
    S_DONE     = 3'd5
  } state_t;

endpackage

// File: rtl/vocab_matcher.sv
// Exact-match search of a NUL-terminated word against a NUL-separated vocab list in SRAM.
// Define MATCHER_MATCH_ADDR_EN to expose match_addr (start address of the matched word).
module vocab_matcher
  import matcher_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_W_DEF,
  parameter int unsigned DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cs,
  input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
  input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
  input  logic [ADDR_WIDTH-1:0] input_start_addr,
  input  logic [DATA_WIDTH-1:0] val_vocab,
  input  logic [DATA_WIDTH-1:0] val_input,
  output logic [ADDR_WIDTH-1:0] addr_v,
  output logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  found,
  output logic                  done
`ifdef MATCHER_MATCH_ADDR_EN
  ,
  output logic [ADDR_WIDTH-1:0] match_addr
`endif
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_v_d, addr_i_d;
  logic                  found_d, done_d;
  logic [ADDR_WIDTH-1:0] vocab_end_q, vocab_end_d;
  logic [ADDR_WIDTH-1:0] input_start_q, input_start_d;
`ifdef MATCHER_MATCH_ADDR_EN
  logic [ADDR_WIDTH-1:0] word_start_q, word_start_d;
  logic [ADDR_WIDTH-1:0] match_addr_d;
`endif

  logic v_nul, chars_eq, at_end, i_wrap;
  logic step_past, skip_adv, finish_miss;

  assign v_nul    = (val_vocab == DATA_WIDTH'(NUL_CHAR));
  assign chars_eq = (val_vocab == val_input);
  assign at_end   = (addr_v == vocab_end_q);
  assign i_wrap   = (addr_i == {ADDR_WIDTH{1'b1}});

  // Next-state and next-register values
  always_comb begin
    state_d       = state_q;
    addr_v_d      = addr_v;
    addr_i_d      = addr_i;
    found_d       = found;
    done_d        = done;
    vocab_end_d   = vocab_end_q;
    input_start_d = input_start_q;
`ifdef MATCHER_MATCH_ADDR_EN
    word_start_d  = word_start_q;
`endif
    step_past     = 1'b0;
    skip_adv      = 1'b0;
    finish_miss   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cs) begin
          vocab_end_d   = vocab_end_addr;
          input_start_d = input_start_addr;
          addr_v_d      = vocab_start_addr;
          addr_i_d      = input_start_addr;
`ifdef MATCHER_MATCH_ADDR_EN
          word_start_d  = vocab_start_addr;
`endif
          state_d       = S_REQ;
        end
      end
      S_REQ:      state_d = S_CMP;
      S_SKIP_REQ: state_d = S_SKIP_CMP;
      S_CMP: begin
        // An input address about to wrap is handled like a character mismatch
        if (chars_eq && v_nul) begin
          found_d = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (chars_eq && at_end) begin
          finish_miss = 1'b1;
        end else if (chars_eq && !i_wrap) begin
          addr_v_d = addr_v + ADDR_WIDTH'(1);
          addr_i_d = addr_i + ADDR_WIDTH'(1);
          state_d  = S_REQ;
        end else if (v_nul) begin
          step_past = 1'b1;
        end else begin
          skip_adv = 1'b1;
        end
      end
      S_SKIP_CMP: begin
        if (v_nul) step_past = 1'b1;
        else       skip_adv  = 1'b1;
      end
      S_DONE: begin
        if (!cs) begin
          found_d = 1'b0;
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Move past a terminator to the next vocab word, restarting the input word
    if (step_past) begin
      if (at_end) begin
        finish_miss = 1'b1;
      end else begin
        addr_v_d     = addr_v + ADDR_WIDTH'(1);
        addr_i_d     = input_start_q;
`ifdef MATCHER_MATCH_ADDR_EN
        word_start_d = addr_v + ADDR_WIDTH'(1);
`endif
        state_d      = S_REQ;
      end
    end

    if (skip_adv) begin
      if (at_end) begin
        finish_miss = 1'b1;
      end else begin
        addr_v_d = addr_v + ADDR_WIDTH'(1);
        state_d  = S_SKIP_REQ;
      end
    end

    if (finish_miss) begin
      found_d = 1'b0;
      done_d  = 1'b1;
      state_d = S_DONE;
    end

    // Dropping cs mid-search abandons it without a result
    if (!cs && state_q != S_IDLE && state_q != S_DONE) begin
      found_d = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end
  end

`ifdef MATCHER_MATCH_ADDR_EN
  assign match_addr_d = found_d ? word_start_d : '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      addr_v        <= '0;
      addr_i        <= '0;
      found         <= 1'b0;
      done          <= 1'b0;
      vocab_end_q   <= '0;
      input_start_q <= '0;
`ifdef MATCHER_MATCH_ADDR_EN
      word_start_q  <= '0;
      match_addr    <= '0;
`endif
    end else begin
      state_q       <= state_d;
      addr_v        <= addr_v_d;
      addr_i        <= addr_i_d;
      found         <= found_d;
      done          <= done_d;
      vocab_end_q   <= vocab_end_d;
      input_start_q <= input_start_d;
`ifdef MATCHER_MATCH_ADDR_EN
      word_start_q  <= word_start_d;
      match_addr    <= match_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_vocab_matcher.sv
// Directed bench for vocab_matcher with behavioural 1-cycle-latency SRAMs.
module tb_vocab_matcher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs = 1'b0;
  logic [3:0] vocab_start_addr = '0;
  logic [3:0] vocab_end_addr = '0;
  logic [3:0] input_start_addr = '0;
  logic [7:0] val_vocab, val_input;
  logic [3:0] addr_v, addr_i;
  logic       found, done;
`ifdef MATCHER_MATCH_ADDR_EN
  logic [3:0] match_addr;
`endif

  logic [7:0] vmem [16];
  logic [7:0] imem [16];

  int total = 0;
  int passed = 0;

  vocab_matcher dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cs               (cs),
    .vocab_start_addr (vocab_start_addr),
    .vocab_end_addr   (vocab_end_addr),
    .input_start_addr (input_start_addr),
    .val_vocab        (val_vocab),
    .val_input        (val_input),
    .addr_v           (addr_v),
    .addr_i           (addr_i),
    .found            (found),
    .done             (done)
`ifdef MATCHER_MATCH_ADDR_EN
    ,
    .match_addr       (match_addr)
`endif
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    val_vocab <= vmem[addr_v];
    val_input <= imem[addr_i];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin
      vmem[i] = 8'h00;
      imem[i] = 8'h00;
    end
  endtask

  task automatic start(input logic [3:0] vs, input logic [3:0] ve, input logic [3:0] is);
    @(negedge clk);
    vocab_start_addr = vs;
    vocab_end_addr   = ve;
    input_start_addr = is;
    cs = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    @(negedge clk);
    while (done !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  task automatic stop(input string tag);
    cs = 1'b0;
    @(negedge clk);
    check(tag, {30'd0, found, done}, 32'd0);
  endtask

  task automatic load_cat_dog();
    clear_mem();
    vmem[0] = "c"; vmem[1] = "a"; vmem[2] = "t"; vmem[3] = 8'h00;
    vmem[4] = "d"; vmem[5] = "o"; vmem[6] = "g"; vmem[7] = 8'h00;
    imem[0] = "d"; imem[1] = "o"; imem[2] = "g"; imem[3] = 8'h00;
  endtask

  initial begin
    clear_mem();
    #12;
    check("reset_outputs", {22'd0, addr_v, addr_i, found, done}, 32'd0);
`ifdef MATCHER_MATCH_ADDR_EN
    check("reset_match_addr", 32'(match_addr), 32'd0);
`endif
    rst_n = 1'b1;

    // "dog" found as second word
    load_cat_dog();
    start(4'd0, 4'd15, 4'd0);
    wait_done("dog_done");
    check("dog_found", 32'(found), 32'd1);
    check("dog_addr_v", 32'(addr_v), 32'd7);
    check("dog_addr_i", 32'(addr_i), 32'd3);
`ifdef MATCHER_MATCH_ADDR_EN
    check("dog_match_addr", 32'(match_addr), 32'd4);
`endif
    stop("dog_clear");

    // "cow" absent: scan runs to the end address and stops there
    imem[0] = "c"; imem[1] = "o"; imem[2] = "w";
    start(4'd0, 4'd15, 4'd0);
    wait_done("cow_done");
    check("cow_found", 32'(found), 32'd0);
    check("cow_addr_v", 32'(addr_v), 32'd15);
    stop("cow_clear");

    // exact latency: 3 chars x 2 cycles after the cs edge
    clear_mem();
    vmem[0] = "a"; vmem[1] = "b";
    imem[0] = "a"; imem[1] = "b";
    start(4'd0, 4'd2, 4'd0);
    repeat (6) @(negedge clk);
    check("lat_not_yet", 32'(done), 32'd0);
    @(negedge clk);
    check("lat_done", {30'd0, found, done}, 32'd3);
    check("lat_addr_v", 32'(addr_v), 32'd2);
    stop("lat_clear");

    // prefix word "cats" must not match "cat"
    clear_mem();
    vmem[0] = "c"; vmem[1] = "a"; vmem[2] = "t"; vmem[3] = "s";
    vmem[5] = "c"; vmem[6] = "a"; vmem[7] = "t";
    imem[0] = "c"; imem[1] = "a"; imem[2] = "t";
    start(4'd0, 4'd15, 4'd0);
    wait_done("cats_done");
    check("cats_found", 32'(found), 32'd1);
    check("cats_addr_v", 32'(addr_v), 32'd8);
`ifdef MATCHER_MATCH_ADDR_EN
    check("cats_match_addr", 32'(match_addr), 32'd5);
`endif
    stop("cats_clear");

    // async reset mid-search, then a clean rerun
    load_cat_dog();
    start(4'd0, 4'd15, 4'd0);
    repeat (8) @(negedge clk);
    check("mid_not_done", 32'(done), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_reset_outputs", {22'd0, addr_v, addr_i, found, done}, 32'd0);
    cs = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start(4'd0, 4'd15, 4'd0);
    wait_done("rerun_done");
    check("rerun_found", 32'(found), 32'd1);
    check("rerun_addr_v", 32'(addr_v), 32'd7);

    // result held while cs stays high
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_stable", {28'd0, addr_v[1:0], found, done}, {28'd0, 2'd3, 1'b1, 1'b1});
    end
    stop("hold_clear");
    start(4'd0, 4'd15, 4'd0);
    wait_done("again_done");
    check("again_found", 32'(found), 32'd1);
    stop("again_clear");

    // cs dropped mid-search aborts without a result
    start(4'd0, 4'd15, 4'd0);
    repeat (5) @(negedge clk);
    cs = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_clear", {30'd0, found, done}, 32'd0);
    repeat (30) @(negedge clk);
    check("abort_stays_idle", 32'(done), 32'd0);

    // empty input matches the first empty vocab entry
    clear_mem();
    vmem[0] = "c"; vmem[1] = "a"; vmem[2] = "t";
    vmem[5] = "d"; vmem[6] = "o"; vmem[7] = "g";
    start(4'd0, 4'd7, 4'd0);
    wait_done("empty_done");
    check("empty_found", 32'(found), 32'd1);
    check("empty_addr_v", 32'(addr_v), 32'd4);
`ifdef MATCHER_MATCH_ADDR_EN
    check("empty_match_addr", 32'(match_addr), 32'd4);
`endif
    stop("empty_clear");

    // matching char on the last vocab address is an overflow, not a match
    clear_mem();
    vmem[0] = "a"; vmem[1] = "b";
    imem[0] = "a"; imem[1] = "b";
    start(4'd0, 4'd1, 4'd0);
    wait_done("ovf_done");
    check("ovf_found", 32'(found), 32'd0);
    check("ovf_addr_v", 32'(addr_v), 32'd1);
    stop("ovf_clear");

    // input address wrap counts as a mismatch (wrapped data would otherwise match)
    clear_mem();
    vmem[0] = "a"; vmem[1] = "b"; vmem[2] = "c";
    imem[14] = "a"; imem[15] = "b"; imem[0] = "c";
    start(4'd0, 4'd7, 4'd14);
    wait_done("wrap_done");
    check("wrap_found", 32'(found), 32'd0);
    check("wrap_addr_v", 32'(addr_v), 32'd7);
    stop("wrap_clear");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
